// File: rtl/fp_pkg.sv
// Shared definitions for the iterative FP divider.
// Contents: divider FSM state enum, per-format exponent/mantissa widths and
// biases, iteration counts, canonical NaN / infinity / max-finite encodings,
// and a helper that places a sign bit for either format.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    DIVIDE,
    ROUND,
    DONE
  } state_t;

  // Single precision (8/23)
  localparam int SP_EXP_W = 8;
  localparam int SP_MAN_W = 23;
  localparam int SP_BIAS  = 127;
  // Half precision (5/10)
  localparam int HP_EXP_W = 5;
  localparam int HP_MAN_W = 10;
  localparam int HP_BIAS  = 15;

  // Quotient bits: significand + guard + one extra for the normalise shift
  localparam int SP_ITER = 26;
  localparam int HP_ITER = 13;

  localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] HP_QNAN = 32'h0000_7E00;
  localparam logic [31:0] SP_INF  = 32'h7F80_0000;
  localparam logic [31:0] HP_INF  = 32'h0000_7C00;
  localparam logic [31:0] SP_MAX  = 32'h7F7F_FFFF;
  localparam logic [31:0] HP_MAX  = 32'h0000_7BFF;

  // Sign bit in its format position (bit 31 single, bit 15 half)
  function automatic logic [31:0] sign_mask(input logic s, input logic fp);
    return fp ? {s, 31'b0} : {16'b0, s, 15'b0};
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational operand unpacker shared by both divider operands.
// Ports: word (packed operand, half in [15:0]), mode_fp (1 single, 0 half);
// sign, expo (biased exponent, zero-extended), sig (significand with hidden
// bit, left-aligned to bit 23 in both formats), is_zero / is_inf / is_nan.
// Subnormals report is_zero: the divider flushes them.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0] word,
  input  logic        mode_fp,
  output logic        sign,
  output logic [7:0]  expo,
  output logic [23:0] sig,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);

  logic exp_max;
  logic man_nz;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a variable unassigned (that would infer a latch).
    sign    = 1'b0;
    expo    = '0;
    sig     = '0;
    exp_max = 1'b0;
    man_nz  = 1'b0;
    if (mode_fp) begin
      sign    = word[31];
      expo    = word[30:SP_MAN_W];
      sig     = {1'b1, word[SP_MAN_W-1:0]};
      exp_max = &word[30:SP_MAN_W];
      man_nz  = |word[SP_MAN_W-1:0];
    end else begin
      sign    = word[15];
      expo    = {3'b0, word[14:HP_MAN_W]};
      // Left-align so the divider datapath is identical for both formats
      sig     = {1'b1, word[HP_MAN_W-1:0], 13'b0};
      exp_max = &word[14:HP_MAN_W];
      man_nz  = |word[HP_MAN_W-1:0];
    end
  end

  assign is_zero = (expo == 8'd0);
  assign is_inf  = exp_max & ~man_nz;
  assign is_nan  = exp_max & man_nz;

endmodule

// File: rtl/fdiv_iter.sv
// Multi-cycle IEEE-754 divider (single or half precision), op_a / op_b,
// restoring radix-2, one quotient bit per cycle, start/done handshake.
// Ports: clk, rst (sync active-high), start, op_a, op_b, round_mode
// (0 RNE, 1 truncate), mode_fp (1 single, 0 half); busy, done (1-cycle
// pulse), result, div_by_zero, invalid (all registered, held until next done).
module fdiv_iter
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        round_mode,
  input  logic        mode_fp,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        invalid
);

  state_t             state;
  logic [31:0]        a_reg, b_reg;
  logic               rm_reg, fp_reg;
  logic [24:0]        rem;       // partial remainder, < 2*divisor
  logic [23:0]        dvs;       // divisor significand
  logic [25:0]        q;         // quotient bits, LSB-first shift-in
  logic [4:0]         cnt;
  logic signed [9:0]  exp_q;     // ea - eb + bias, before normalisation
  logic               sign_q;
  logic               sp_q, sp_dz_q, sp_inv_q;
  logic [31:0]        sp_res_q;

  logic        sa, sb, za, zb, ia, ib, na, nb;
  logic [7:0]  ea, eb;
  logic [23:0] ga, gb;

  fp_unpack u_unpack_a (
    .word(a_reg), .mode_fp(fp_reg), .sign(sa), .expo(ea), .sig(ga),
    .is_zero(za), .is_inf(ia), .is_nan(na)
  );

  fp_unpack u_unpack_b (
    .word(b_reg), .mode_fp(fp_reg), .sign(sb), .expo(eb), .sig(gb),
    .is_zero(zb), .is_inf(ib), .is_nan(nb)
  );

  // Special-case classification, consumed in UNPACK
  logic        sp_n, sp_dz_n, sp_inv_n;
  logic [31:0] sp_res_n;

  always_comb begin
    sp_n     = 1'b1;
    sp_dz_n  = 1'b0;
    sp_inv_n = 1'b0;
    sp_res_n = sign_mask(sa ^ sb, fp_reg);
    if (na | nb | (za & zb) | (ia & ib)) begin
      sp_res_n = fp_reg ? SP_QNAN : HP_QNAN;
      sp_inv_n = 1'b1;
    end else if (zb & ~ia) begin
      sp_res_n = sp_res_n | (fp_reg ? SP_INF : HP_INF);
      sp_dz_n  = 1'b1;
    end else if (ia) begin
      sp_res_n = sp_res_n | (fp_reg ? SP_INF : HP_INF);
    end else if (!(za | ib)) begin
      sp_n = 1'b0;   // za | ib leave the signed zero already in sp_res_n
    end
  end

  // Normalise, round and pack the iterative quotient
  logic              msb, guard, sticky, round_up, carry;
  logic [23:0]       mant;
  logic [22:0]       frac_r;
  logic signed [9:0] exp_f;
  logic [31:0]       norm_res;

  always_comb begin
    msb  = fp_reg ? q[25] : q[12];
    mant = '0;
    if (fp_reg) mant = msb ? q[25:2] : q[24:1];
    else        mant = {13'b0, (msb ? q[12:2] : q[11:1])};
    // Guard sits at the same quotient position in both formats
    guard    = msb ? q[1] : q[0];
    sticky   = (msb & q[0]) | (rem != '0);
    round_up = ~rm_reg & guard & (sticky | mant[0]);
    // An all-ones significand rounding up carries into the exponent; the
    // wrapped fraction is then correctly zero.
    carry    = round_up & (fp_reg ? &mant[23:0] : &mant[10:0]);
    frac_r   = mant[22:0] + {22'b0, round_up};
    exp_f    = exp_q - (msb ? 10'sd0 : 10'sd1) + (carry ? 10'sd1 : 10'sd0);
    norm_res = sign_mask(sign_q, fp_reg);
    if (exp_f >= (fp_reg ? 10'sd255 : 10'sd31))
      norm_res = norm_res | (rm_reg ? (fp_reg ? SP_MAX : HP_MAX)
                                    : (fp_reg ? SP_INF : HP_INF));
    else if (exp_f >= 10'sd1)
      norm_res = fp_reg ? {sign_q, exp_f[7:0], frac_r}
                        : {16'b0, sign_q, exp_f[4:0], frac_r[9:0]};
    // else: underflow, no subnormal outputs -> signed zero as preset
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only control and visible outputs are reset; the datapath
      // registers are always loaded before use, so resetting them buys nothing.
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= op_a;
            b_reg  <= op_b;
            rm_reg <= round_mode;
            fp_reg <= mode_fp;
            busy   <= 1'b1;
            state  <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q   <= sa ^ sb;
          exp_q    <= $signed({2'b00, ea}) - $signed({2'b00, eb})
                      + (fp_reg ? 10'(SP_BIAS) : 10'(HP_BIAS));
          rem      <= {1'b0, ga};
          dvs      <= gb;
          q        <= '0;
          cnt      <= fp_reg ? 5'(SP_ITER - 1) : 5'(HP_ITER - 1);
          sp_q     <= sp_n;
          sp_dz_q  <= sp_dz_n;
          sp_inv_q <= sp_inv_n;
          sp_res_q <= sp_res_n;
          state    <= sp_n ? ROUND : DIVIDE;
        end
        DIVIDE: begin
          if (rem >= {1'b0, dvs}) begin
            q   <= {q[24:0], 1'b1};
            rem <= (rem - {1'b0, dvs}) << 1;
          end else begin
            q   <= {q[24:0], 1'b0};
            rem <= rem << 1;
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= ROUND;
        end
        ROUND: begin
          result      <= sp_q ? sp_res_q : norm_res;
          div_by_zero <= sp_q & sp_dz_q;
          invalid     <= sp_q & sp_inv_q;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
// Directed self-checking bench for fdiv_iter: hand-computed quotients,
// latency, busy/done handshake, ignored starts and mid-operation reset.
module tb_fdiv_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        round_mode = 1'b0;
  logic        mode_fp = 1'b1;
  logic        busy, done, div_by_zero, invalid;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fdiv_iter dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .round_mode(round_mode), .mode_fp(mode_fp), .busy(busy), .done(done),
    .result(result), .div_by_zero(div_by_zero), .invalid(invalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Issues one operation, pulses a
  // foreign start mid-flight and another in the done cycle, then checks.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic rm, input logic fp, input logic [31:0] exp_res,
                       input logic exp_dz, input logic exp_inv, input int exp_lat);
    int   n;
    logic busy_ok;
    op_a = a; op_b = b; round_mode = rm; mode_fp = fp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (n == 4) begin
        start = 1'b1; op_a = 32'h4480_0000; op_b = 32'h3F80_0000;
        round_mode = ~rm; mode_fp = ~fp;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy !== 1'b1) busy_ok = 1'b0;
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " busy_high"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, exp_dz});
    chk({tag, " invalid"}, {31'b0, invalid}, {31'b0, exp_inv});
    // start during the done cycle must be ignored
    start = 1'b1; op_a = 32'h3F80_0000; op_b = 32'h0000_0000; mode_fp = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after"}, {31'b0, busy}, 32'd0);
    chk({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, " result_hold"}, result, exp_res);
  endtask

  initial begin : stim
    int   n;
    logic saw_done;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst dz", {31'b0, div_by_zero}, 32'd0);
    chk("rst inv", {31'b0, invalid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal single / half divides
    do_op("sp 6/2",      32'h40C0_0000, 32'h4000_0000, 1'b0, 1'b1, 32'h4040_0000, 1'b0, 1'b0, 29);
    do_op("sp 1/3 rne",  32'h3F80_0000, 32'h4040_0000, 1'b0, 1'b1, 32'h3EAA_AAAB, 1'b0, 1'b0, 29);
    do_op("sp 1/3 rtz",  32'h3F80_0000, 32'h4040_0000, 1'b1, 1'b1, 32'h3EAA_AAAA, 1'b0, 1'b0, 29);
    do_op("hp 1/3",      32'h0000_3C00, 32'h0000_4200, 1'b0, 1'b0, 32'h0000_3555, 1'b0, 1'b0, 16);
    do_op("hp -4/0.5",   32'h0000_C400, 32'h0000_3800, 1'b0, 1'b0, 32'h0000_C800, 1'b0, 1'b0, 16);
    // Overflow and underflow boundaries
    do_op("sp ovf rne",  32'h7F00_0000, 32'h3F00_0000, 1'b0, 1'b1, 32'h7F80_0000, 1'b0, 1'b0, 29);
    do_op("sp ovf rtz",  32'h7F00_0000, 32'h3F00_0000, 1'b1, 1'b1, 32'h7F7F_FFFF, 1'b0, 1'b0, 29);
    do_op("sp unf neg",  32'h8080_0000, 32'h7F00_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 29);
    // Special cases
    do_op("sp 1/0",      32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h7F80_0000, 1'b1, 1'b0, 3);
    do_op("sp 0/0",      32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h7FC0_0000, 1'b0, 1'b1, 3);
    do_op("hp inf/inf",  32'h0000_7C00, 32'h0000_7C00, 1'b0, 1'b0, 32'h0000_7E00, 1'b0, 1'b1, 3);
    do_op("sp -0/2",     32'h8000_0000, 32'h4000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 3);

    // Reset during a single divide
    op_a = 32'h40C0_0000; op_b = 32'h4000_0000; round_mode = 1'b0; mode_fp = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst dz", {31'b0, div_by_zero}, 32'd0);
    chk("midrst inv", {31'b0, invalid}, 32'd0);
    saw_done = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("midrst no_done", {31'b0, saw_done}, 32'd0);

    do_op("sp 6/2 again", 32'h40C0_0000, 32'h4000_0000, 1'b0, 1'b1, 32'h4040_0000, 1'b0, 1'b0, 29);
    do_op("hp back2back", 32'h0000_C400, 32'h0000_3800, 1'b0, 1'b0, 32'h0000_C800, 1'b0, 1'b0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fdiv_iter.md
# fdiv_iter

Multi-cycle IEEE-754 floating-point divider for the FP unit, computing op_a / op_b in single precision (mode_fp=1) or half precision (mode_fp=0, operands and result in bits [15:0]). It uses the same operand, round_mode and mode_fp conventions as the combinational add/sub path, but wraps the slow operation in a start/done handshake so the datapath can issue it and collect the result later. It uses a restoring radix-2 mantissa divider, one quotient bit per cycle.

## Interface
Parameters:
- none; all widths come from the shared package.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op_a  in  32  dividend; bits [15:0] only when mode_fp=0
- op_b  in  32  divisor; bits [15:0] only when mode_fp=0
- round_mode  in  1  0 = round-to-nearest-even, 1 = toward zero (truncate)
- mode_fp  in  1  1 = single (8/23), 0 = half (5/10)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result and flags are valid that cycle
- result  out  32  quotient; upper 16 bits are zero in half mode
- div_by_zero  out  1  finite nonzero / zero; valid with done
- invalid  out  1  0/0, inf/inf, or any NaN operand; valid with done

## Operation
- Input capture: in IDLE with start=1, register op_a, op_b, round_mode and mode_fp. Input changes after that cycle have no effect.
- States and transitions:
  - IDLE -> UNPACK on start.
  - UNPACK -> DIVIDE for normal operands.
  - UNPACK -> ROUND when a special case is detected.
  - DIVIDE -> ROUND after K iterations.
  - ROUND -> DONE.
  - DONE -> IDLE.
- Iteration count K: 26 in single (24 quotient bits + guard + 1 extra bit for the normalise shift), 13 in half. The remainder's nonzero state becomes the sticky bit.
- Exponent: ea - eb + bias. If the quotient MSB is 0, shift left by 1 and decrement the exponent.
- Rounding: RNE uses guard, round and sticky. A mantissa carry-out increments the exponent.
- Overflow: the result is ±inf for RNE and ±max-finite for truncate.
- Underflow and subnormal handling:
  - Subnormal inputs are treated as zero.
  - An exponent below 1 produces signed zero; there are no subnormal outputs.
- Sign: sign_a XOR sign_b, including on zero and inf results.
- Special cases, evaluated in UNPACK in this order:
  - Any NaN, 0/0 or inf/inf gives canonical NaN (0x7FC00000 single, 0x00007E00 half) and sets invalid.
  - Finite/0 gives ±inf and sets div_by_zero.
  - inf/finite gives ±inf.
  - 0/nonzero and finite/inf give ±0.
- Outputs: result, div_by_zero and invalid hold their values from DONE until the next DONE.
- start while busy is ignored; it is neither queued nor allowed to corrupt the operation in flight.
- Reset, including in the middle of an operation:
  - State returns to IDLE.
  - busy=0, done=0, result=0, div_by_zero=0, invalid=0.
  - No done pulse is produced for the aborted operation.

## Timing
- start is sampled at edge t. done is high during:
  - cycle t+3+K for normal operands: t+29 single, t+16 half;
  - cycle t+3 for special cases.
- busy rises at t+1 and falls when DONE exits, so start can be accepted in the cycle right after done.
- A start asserted in the same cycle as done is ignored, because the FSM is in DONE, not IDLE.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package fp_pkg contains:
  - the state enum (IDLE, UNPACK, DIVIDE, ROUND, DONE);
  - exponent and mantissa widths and biases per format;
  - iteration counts (26/13);
  - canonical NaN and inf constants for both formats.
- Sub-module fp_unpack (combinational), used for both operands:
  - inputs: word and mode_fp;
  - outputs: sign, exponent, significand with hidden bit, and is_zero/is_inf/is_nan flags.
- Remaining logic (FSM, iteration counter, remainder/quotient registers, round logic) lives in fdiv_iter.

## Test plan
- Single, RNE, 0x40C00000 / 0x40000000 (6/2) -> result 0x40400000, flags 0, done exactly 29 cycles after start, busy high in between.
- Single 1/3, 0x3F800000 / 0x40400000 -> 0x3EAAAAAB with round_mode=0 and 0x3EAAAAAA with round_mode=1.
- Half:
  - 0x3C00 / 0x4200 -> 0x00003555, done at t+16;
  - 0xC400 / 0x3800 -> 0x0000C800.
- Specials, each with done at t+3:
  - 0x3F800000 / 0 -> 0x7F800000 with div_by_zero=1;
  - 0 / 0 -> 0x7FC00000 with invalid=1;
  - half 0x7C00 / 0x7C00 -> 0x00007E00 with invalid=1.
- Reset asserted at t+10 during a single divide -> all outputs 0 the next cycle and no done pulse. A fresh 6/2 divide afterwards completes normally.
- Handshake:
  - start pulses with different operands during busy are ignored, and the first result is unchanged;
  - start in the done cycle is ignored;
  - start in the following cycle is accepted;
  - back-to-back operations give correct results.
